// File: rtl/dc_fu_axi_read_responder.sv
// dc_fu_axi_read_responder: AXI4 read slave over a 1-cycle-latency word memory; WRAP bursts enabled by DC_FU_AXI_RD_WRAP_EN
module dc_fu_axi_read_responder #(
    parameter int AXI_ARADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH   = 12,
    parameter int AR_QUEUE_DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic [7:0]                  axi_arid,
    input  logic [AXI_ARADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]                  axi_arlen,
    input  logic [2:0]                  axi_arsize,
    input  logic [1:0]                  axi_arburst,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [7:0]                  axi_rid,
    output logic [15:0]                 axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready,
    output logic                        mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [15:0]                 mem_rd_data
);
    localparam int QW = $clog2(AR_QUEUE_DEPTH);
    localparam int WW = AXI_ARADDR_WIDTH - 1;
    localparam logic [QW:0] Q_FULL = (QW+1)'(AR_QUEUE_DEPTH);

    typedef struct packed {
        logic [7:0]                  id;
        logic [AXI_ARADDR_WIDTH-1:0] addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
    } ar_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef enum logic {IDLE, BURST} state_t;

    ar_t           q_mem [AR_QUEUE_DEPTH];
    ar_t           head;
    logic [QW-1:0] q_wr, q_rd;
    logic [QW:0]   q_cnt, q_cnt_nxt;
    logic          arready_q, q_push, q_pop, q_empty;

    state_t        state, state_nxt;
    logic [7:0]    cur_id, cur_len, beat_cnt;
    logic [1:0]    cur_burst;
    logic          burst_err, head_err;
    logic [WW-1:0] word_addr, wa_inc, wa_nxt;
    logic          retire, slot_ok, issue, last_beat, beat_err;

    logic          infl_valid, infl_err, infl_last;
    logic [7:0]    infl_id;
    r_t            rbuf [2];
    r_t            rhead;
    logic          r_wr, r_rd;
    logic [1:0]    r_cnt;

    assign head        = q_mem[q_rd];
    assign q_empty     = q_cnt == '0;
    assign q_push      = axi_arvalid && arready_q;
    assign q_cnt_nxt   = q_cnt + (QW+1)'(q_push) - (QW+1)'(q_pop);
    assign axi_arready = arready_q;

    always_ff @(posedge clk)
        if (q_push) q_mem[q_wr] <= '{axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst};

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            q_wr      <= '0;
            q_rd      <= '0;
            q_cnt     <= '0;
            arready_q <= 1'b0;
        end else begin
            q_wr      <= q_wr + QW'(q_push);
            q_rd      <= q_rd + QW'(q_pop);
            q_cnt     <= q_cnt_nxt;
            arready_q <= en && q_cnt_nxt < Q_FULL;
        end

    // Request-level legality; the per-beat range check is added at issue time
    always_comb begin
        head_err = head.size != 3'b001 || head.addr[0] || head.burst == 2'b11;
`ifdef DC_FU_AXI_RD_WRAP_EN
        head_err = head_err || (head.burst == 2'b10 && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
        head_err = head_err || head.burst == 2'b10;
`endif
    end

    // A slot is free if fewer than two beats are buffered or in flight, or one leaves this cycle
    assign retire    = axi_rvalid && axi_rready;
    assign slot_ok   = ({1'b0, r_cnt} + {2'b00, infl_valid}) < 3'd2 || retire;
    assign issue     = en && state == BURST && slot_ok;
    assign last_beat = beat_cnt == cur_len;
    assign beat_err  = burst_err || (|word_addr[WW-1:MEM_ADDR_WIDTH]);
    assign q_pop     = en && !q_empty && (state == IDLE || (issue && last_beat));

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) state <= IDLE;
        else state <= state_nxt;

    always_comb state_nxt = q_pop ? BURST : (issue && last_beat) ? IDLE : state;

    always_comb begin
        mem_rd_en   = issue && !beat_err;
        mem_rd_addr = word_addr[MEM_ADDR_WIDTH-1:0];
    end

`ifdef DC_FU_AXI_RD_WRAP_EN
    logic [WW-1:0] wmask;
    assign wmask = {{(WW-8){1'b0}}, cur_len};
`endif

    always_comb begin
        wa_inc = word_addr + WW'(1);
        wa_nxt = cur_burst == 2'b00 ? word_addr : wa_inc;
`ifdef DC_FU_AXI_RD_WRAP_EN
        if (cur_burst == 2'b10) wa_nxt = (word_addr & ~wmask) | (wa_inc & wmask);
`endif
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            cur_id    <= '0;
            cur_len   <= '0;
            cur_burst <= '0;
            burst_err <= 1'b0;
            beat_cnt  <= '0;
            word_addr <= '0;
        end else if (q_pop) begin
            cur_id    <= head.id;
            cur_len   <= head.len;
            cur_burst <= head.burst;
            burst_err <= head_err;
            beat_cnt  <= '0;
            word_addr <= head.addr[AXI_ARADDR_WIDTH-1:1];
        end else if (issue) begin
            beat_cnt  <= beat_cnt + 8'd1;
            word_addr <= wa_nxt;
        end

    // Error beats ride the same pipeline so every beat has identical latency
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            infl_valid <= 1'b0;
            infl_err   <= 1'b0;
            infl_last  <= 1'b0;
            infl_id    <= '0;
        end else begin
            infl_valid <= issue;
            if (issue) begin
                infl_err  <= beat_err;
                infl_last <= last_beat;
                infl_id   <= cur_id;
            end
        end

    always_ff @(posedge clk)
        if (infl_valid) rbuf[r_wr] <= {infl_id, infl_err ? 16'h0 : mem_rd_data, infl_err ? 2'b10 : 2'b00, infl_last};

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr ^ infl_valid;
            r_rd  <= r_rd ^ retire;
            r_cnt <= r_cnt + {1'b0, infl_valid} - {1'b0, retire};
        end

    assign rhead      = rbuf[r_rd];
    assign axi_rvalid = r_cnt != 2'd0;
    assign axi_rid    = axi_rvalid ? rhead.id : 8'h0;
    assign axi_rdata  = axi_rvalid ? rhead.data : 16'h0;
    assign axi_rresp  = axi_rvalid ? rhead.resp : 2'b00;
    assign axi_rlast  = axi_rvalid && rhead.last;
endmodule

// File: tb/tb_dc_fu_axi_read_responder.sv
// tb_dc_fu_axi_read_responder: directed vector bench for the AXI read responder with a 1-cycle memory model
module tb_dc_fu_axi_read_responder;
    logic        clk = 1'b0;
    logic        nrst, en;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid, axi_arready;
    logic [7:0]  axi_rid;
    logic [15:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast, axi_rvalid, axi_rready;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [15:0] mem_rd_data = 16'h0;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          w0;
        int          ok;
    } vec_t;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] data;
        logic [1:0]  resp;
        logic        last;
        int          cyc;
    } beat_t;

    logic [15:0] mem [4096];
    beat_t       got[$];
    vec_t        vecs[7];
    int          total = 0, bad = 0;
    int          cyc = 0, pend = 0, pend_viol = 0, stall_bad = 0, rd_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_pl = '0;
    logic        rmode = 1'b0;

    dc_fu_axi_read_responder dut (
        .clk(clk), .nrst(nrst), .en(en),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // rready is 1 or the repeating 1,0,0,1,0 backpressure pattern
    initial begin
        logic [4:0] pat;
        int rpos;
        pat = 5'b01001;
        rpos = 0;
        axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axi_rready = rmode ? pat[rpos % 5] : 1'b1;
            rpos++;
        end
    end

    always @(negedge clk) begin
        if (!nrst) begin
            pend = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!axi_rvalid || {axi_rid, axi_rdata, axi_rresp, axi_rlast} != prev_pl)) stall_bad++;
            if (mem_rd_en && pend >= 2 && !(axi_rvalid && axi_rready)) pend_viol++;
            if (mem_rd_en) begin
                pend++;
                rd_cnt++;
            end
            if (axi_rvalid && axi_rready) begin
                got.push_back('{axi_rid, axi_rdata, axi_rresp, axi_rlast, cyc});
                if (axi_rresp == 2'b00) pend--;
            end
            prev_stall = axi_rvalid && !axi_rready;
            prev_pl = {axi_rid, axi_rdata, axi_rresp, axi_rlast};
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic send_ar(input vec_t v);
        logic ok;
        ok = 1'b0;
        axi_arid = v.id;
        axi_araddr = v.addr;
        axi_arlen = v.len;
        axi_arsize = v.size;
        axi_arburst = v.burst;
        axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = axi_arready;
            @(posedge clk);
            #1;
        end
        axi_arvalid = 1'b0;
        chk("ar_handshake", int'(ok), 1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 300 && got.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_beats(input vec_t v, input int base, input string nm);
        for (int i = 0; i <= int'(v.len) && base + i < got.size(); i++) begin
            int w;
            logic [15:0] ed;
            logic [1:0] er;
            logic el;
            beat_t b;
            w = v.burst == 2'b00 ? v.w0 : v.burst == 2'b01 ? v.w0 + i :
                ((v.w0 & ~int'(v.len)) | ((v.w0 + i) & int'(v.len)));
            ed = i < v.ok ? (16'(w) ^ 16'hA5A5) : 16'h0;
            er = i < v.ok ? 2'b00 : 2'b10;
            el = i == int'(v.len);
            b = got[base + i];
            total++;
            if ({b.id, b.data, b.resp, b.last} !== {v.id, ed, er, el}) begin
                bad++;
                $display("FAIL %s beat %0d: got id=%h data=%h resp=%b last=%b, want id=%h data=%h resp=%b last=%b",
                         nm, i, b.id, b.data, b.resp, b.last, v.id, ed, er, el);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int r0;
        r0 = rd_cnt;
        send_ar(v);
        wait_beats(int'(v.len) + 1);
        chk({nm, "_count"}, got.size(), int'(v.len) + 1);
        check_beats(v, 0, nm);
        chk({nm, "_mem_reads"}, rd_cnt - r0, v.ok);
        got.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t va, vb, vr;
        int n, hs;
        vecs[0] = '{8'h03, 32'h100, 8'd15, 3'b001, 2'b01, 'h80, 16};
        vecs[1] = '{8'h05, 32'h1FFC, 8'd3, 3'b001, 2'b01, 'hFFE, 2};
`ifdef DC_FU_AXI_RD_WRAP_EN
        vecs[2] = '{8'h07, 32'h10C, 8'd3, 3'b001, 2'b10, 'h86, 4};
`else
        vecs[2] = '{8'h07, 32'h10C, 8'd3, 3'b001, 2'b10, 'h86, 0};
`endif
        vecs[3] = '{8'h06, 32'h101, 8'd1, 3'b001, 2'b01, 'h80, 0};
        vecs[4] = '{8'h09, 32'h040, 8'd2, 3'b001, 2'b00, 'h20, 3};
        vecs[5] = '{8'h0A, 32'h100, 8'd0, 3'b010, 2'b01, 'h80, 0};
        vecs[6] = '{8'h0B, 32'h010, 8'd1, 3'b001, 2'b11, 'h08, 0};
        va = '{8'h01, 32'h000, 8'd3, 3'b001, 2'b01, 'h0, 4};
        vb = '{8'h02, 32'h200, 8'd1, 3'b001, 2'b01, 'h100, 2};
        vr = '{8'h22, 32'h300, 8'd1, 3'b001, 2'b01, 'h180, 2};
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        nrst = 1'b0;
        en = 1'b1;
        axi_arvalid = 1'b0;
        axi_arid = '0;
        axi_araddr = '0;
        axi_arlen = '0;
        axi_arsize = '0;
        axi_arburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", int'(axi_arready), 0);
        chk("rst_rvalid", int'(axi_rvalid), 0);
        chk("rst_mem_rd_en", int'(mem_rd_en), 0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("arready_first_cycle", int'(axi_arready), 0);
        @(negedge clk);
        chk("arready_up", int'(axi_arready), 1);
        @(posedge clk);
        #1;

        send_ar(vecs[0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!axi_rvalid && n < 20);
        chk("first_rvalid_latency", n - 1, 3);
        @(posedge clk);
        #1;
        wait_beats(16);
        chk("lat_count", got.size(), 16);
        check_beats(vecs[0], 0, "lat_burst");
        got.delete();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        rmode = 1'b1;
        run_vec(vecs[0], "backpressure");
        rmode = 1'b0;
        chk("stall_stability", stall_bad, 0);
        chk("issue_with_two_pending", pend_viol, 0);

        send_ar(va);
        send_ar(vb);
        wait_beats(6);
        chk("b2b_count", got.size(), 6);
        check_beats(va, 0, "b2b_a");
        check_beats(vb, 4, "b2b_b");
        chk("b2b_contiguous", got.size() == 6 ? got[5].cyc - got[0].cyc : -1, 5);
        got.delete();

        send_ar(vecs[0]);
        for (int i = 0; i < 100 && got.size() < 5; i++) @(posedge clk);
        @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("async_rst_rvalid", int'(axi_rvalid), 0);
        chk("async_rst_arready", int'(axi_arready), 0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", int'(axi_arready), 0);
        got.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_beats", got.size(), 0);
        run_vec(vr, "post_rst");

        en = 1'b0;
        @(posedge clk);
        #1;
        axi_arvalid = 1'b1;
        hs = 0;
        repeat (5) begin
            @(negedge clk);
            if (axi_arready) hs++;
        end
        chk("en_low_no_accept", hs, 0);
        chk("en_low_no_read", int'(mem_rd_en), 0);
        @(posedge clk);
        #1;
        axi_arvalid = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
